// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared types and default constants for the data memory responder
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEPTH_WORDS_DEF  = 1024;
    localparam int DMEM_READ_LATENCY_DEF = 2;

endpackage : core_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Word storage built from four byte-lane RAMs; synchronous
//            byte-enabled write port and registered read port. Not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
    input  logic [31:0]                    wdata,
    input  logic                           re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
    output logic [31:0]                    rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] rd_byte;

        always_ff @(posedge clock) begin
            if (we && be[i]) begin
                lane_mem[waddr] <= wdata[8*i +: 8];
            end
            if (re) begin
                rd_byte <= lane_mem[raddr];
            end
        end

        assign rdata[8*i +: 8] = rd_byte;
    end

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_resp
// Brief    : LSU data memory with fixed-latency response, one outstanding
//            transaction. Optional macro DMEM_ERR_RESP_EN enables error
//            responses for misaligned / out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS  = DMEM_DEPTH_WORDS_DEF,
    parameter int READ_LATENCY = DMEM_READ_LATENCY_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_state_e   state;
    dmem_state_e   state_next;
    logic [2:0]    cnt;
    logic [2:0]    cnt_next;
    logic          we_q;
    logic          err_q;
    logic [AW-1:0] idx_q;

    logic          accept;
    logic          addr_err;
    logic [AW-1:0] idx_in;
    logic [AW-1:0] rd_idx;
    logic [31:0]   arr_rdata;

    // Gating with reset keeps the grant low while reset is held.
    assign accept     = data_req_i && (state == IDLE) && reset;
    assign data_gnt_o = accept;
    assign idx_in     = data_addr_i[AW+1:2];

`ifdef DMEM_ERR_RESP_EN
    assign addr_err = (data_addr_i[1:0] != 2'b00) ||
                      (data_addr_i[31:2] >= 30'(DEPTH_WORDS));
`else
    logic unused_addr_bits;
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q  <= data_we_i;
                err_q <= addr_err;
                idx_q <= idx_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = 3'(READ_LATENCY - 1);
                    state_next = (READ_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - 3'd1;
                if (cnt == 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With single-cycle latency the read happens on the accept edge itself.
    assign rd_idx = (state == IDLE) ? idx_in : idx_q;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clock (clock),
        .we    (accept && data_we_i && !addr_err),
        .be    (data_be_i),
        .waddr (idx_in),
        .wdata (data_wdata_i),
        .re    (state_next == RESP),
        .raddr (rd_idx),
        .rdata (arr_rdata)
    );

    assign data_rvalid_o = (state == RESP);
    assign busy_o        = (state != IDLE);
    assign data_rdata_o  = (state == RESP && !we_q && !err_q) ? arr_rdata : 32'd0;

`ifdef DMEM_ERR_RESP_EN
    assign data_err_o = (state == RESP) && err_q;
`else
    assign data_err_o = 1'b0;
`endif

endmodule : data_mem_resp
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024 (power of two, 16..65536), the number of 32-bit storage words.
REQ-002 The block SHALL have parameter READ_LATENCY, default 2 (legal 1..7), the cycles from the accept edge to data_rvalid_o.
REQ-003 Port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-005 Port data_req_i, input, 1, request valid from the LSU.
REQ-006 Port data_we_i, input, 1, 1 = store, 0 = load.
REQ-007 Port data_be_i, input, 4, byte-lane enables for stores (bit n = byte n).
REQ-008 Port data_addr_i, input, 32, byte address.
REQ-009 Port data_wdata_i, input, 32, store data.
REQ-010 Port data_gnt_o, output, 1, request accepted this cycle.
REQ-011 Port data_rvalid_o, output, 1, response valid (one-cycle pulse).
REQ-012 Port data_rdata_o, output, 32, load data, valid only with data_rvalid_o.
REQ-013 Port data_err_o, output, 1, access error, valid only with data_rvalid_o.
REQ-014 Port busy_o, output, 1, high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; one transaction outstanding at most.
REQ-016 data_gnt_o SHALL equal data_req_i AND (state == IDLE), combinationally; a cycle with both high is the accept cycle.
REQ-017 On the accept edge the block SHALL capture we, be, addr and wdata, load a latency counter with READ_LATENCY-1, and go to WAIT (or to RESP directly if READ_LATENCY == 1).
REQ-018 In WAIT the counter SHALL decrement each cycle; the state SHALL move to RESP on the edge where the counter is 1.
REQ-019 data_rvalid_o SHALL be high for exactly the one cycle in RESP, exactly READ_LATENCY cycles after the accept cycle; RESP SHALL always return to IDLE.
REQ-020 Stores SHALL commit to storage on the accept edge, updating only lanes with data_be_i set; a store with data_be_i == 0 SHALL change nothing and still respond.
REQ-021 Loads SHALL return the full 32-bit word at index addr[31:2], read at the edge entering RESP; a load following a store to the same word SHALL return the stored data.
REQ-022 data_rdata_o SHALL be 0 for store responses, for error responses and outside RESP.
REQ-023 Requests arriving while not in IDLE SHALL receive no grant and SHALL be held by the requester; inputs other than data_req_i SHALL be ignored outside the accept cycle.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, counter 0 and data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o, busy_o all 0.
REQ-025 Reset mid-transaction SHALL drop the pending response without issuing it; a store already committed on its accept edge SHALL remain in storage.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With macro DMEM_ERR_RESP_EN defined, an access with addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS SHALL write nothing and respond with data_err_o = 1, data_rdata_o = 0, at normal latency.
REQ-028 Without DMEM_ERR_RESP_EN, addr[1:0] SHALL be ignored, the word index SHALL wrap modulo DEPTH_WORDS, and data_err_o SHALL be tied 0.

Structure
REQ-029 CORE_PKG SHALL hold typedef dmem_state_e (IDLE, WAIT, RESP) and constants DMEM_DEPTH_WORDS_DEF = 1024 and DMEM_READ_LATENCY_DEF = 2.
REQ-030 Storage SHALL be a sub-module dmem_array (one synchronous byte-lane write port and one read port); FSM, counter and error check SHALL live in data_mem_resp.

Verification
REQ-031 Latency: load at 0x10 with READ_LATENCY = 3 -> gnt in cycle 0, rvalid only in cycle 3, busy_o high in cycles 1..3.
REQ-032 Byte-lane store: store 0xAABBCCDD to 0x20 with be 0xF, then 0x11223344 with be 0x5 -> load of 0x20 returns 0xAA22CC44.
REQ-033 Back-pressure: hold req through a transaction -> second gnt only in the IDLE cycle after RESP, never during WAIT or RESP.
REQ-034 Errors (macro on): load at 0x22 -> rvalid with err 1 and rdata 0; store at DEPTH_WORDS*4 -> err 1 and no word changed.
REQ-035 Wrap (macro off, DEPTH_WORDS = 16): store 0x5A5A5A5A to 0x40 -> load of 0x00 returns 0x5A5A5A5A and err stays 0.
REQ-036 Reset: assert reset in the cycle after a load accept -> no rvalid ever appears, all outputs 0, and the next request is granted immediately after reset release.
